// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer
// Parses ASCII frames "<A><op><B><term>" arriving byte-by-byte from the UART
// receiver and hands one decoded command to the calculator core over a
// valid/ready handshake. Malformed or overlong frames are discarded with a
// one-cycle frame_error_o pulse.
// Optional feature: define UART_CMD_TIMEOUT_EN to discard a frame whose
// next byte does not arrive within TIMEOUT_MS milliseconds.
module uart_cmd_sequencer #(
    parameter int OPERAND_WIDTH   = 16,
    parameter int MAX_DIGITS      = 4,
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int TIMEOUT_MS      = 100
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [7:0]               byte_data_i,
    input  logic                     byte_ready_i,
    output logic                     cmd_valid_o,
    input  logic                     cmd_ready_i,
    output logic [OPERAND_WIDTH-1:0] operand_a_o,
    output logic [OPERAND_WIDTH-1:0] operand_b_o,
    output logic [1:0]               opcode_o,
    output logic                     frame_error_o,
    output logic                     busy_o
);

    localparam int CNT_WIDTH = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPA   = 2'd1,
        OPB   = 2'd2,
        ISSUE = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [OPERAND_WIDTH-1:0] accA_q, accA_d;
    logic [OPERAND_WIDTH-1:0] accB_q, accB_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic [1:0]               opPending_q, opPending_d;
    logic [1:0]               opcode_q, opcode_d;
    logic [OPERAND_WIDTH-1:0] operandA_q, operandA_d;
    logic [OPERAND_WIDTH-1:0] operandB_q, operandB_d;
    logic                     cmdValid_q, cmdValid_d;
    logic                     frameError_q, frameError_d;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TIMEOUT_LIMIT = CLOCK_FREQUENCY / 1000 * TIMEOUT_MS;
    localparam int TIMER_WIDTH   = $clog2(TIMEOUT_LIMIT + 1);
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
`endif

    logic                     isDigit;
    logic                     isOp;
    logic                     isTerm;
    logic                     isSpace;
    logic [1:0]               opFromByte;
    logic [OPERAND_WIDTH-1:0] digitVal;
    logic [OPERAND_WIDTH-1:0] accANext;
    logic [OPERAND_WIDTH-1:0] accBNext;
    logic                     cntFull;

    // Classify the incoming byte and precompute the decimal shift-in for both accumulators
    always_comb begin
        isDigit    = (byte_data_i >= 8'h30) && (byte_data_i <= 8'h39);
        isSpace    = (byte_data_i == 8'h20);
        isTerm     = (byte_data_i == 8'h0D) || (byte_data_i == 8'h3D);
        isOp       = 1'b1;
        opFromByte = 2'd0;
        case (byte_data_i)
            8'h2B:   opFromByte = 2'd0;
            8'h2D:   opFromByte = 2'd1;
            8'h2A:   opFromByte = 2'd2;
            8'h2F:   opFromByte = 2'd3;
            default: isOp = 1'b0;
        endcase
        // the low nibble of an ASCII digit is its value; multiply-by-ten wraps silently
        digitVal = {{(OPERAND_WIDTH-4){1'b0}}, byte_data_i[3:0]};
        accANext = (accA_q << 3) + (accA_q << 1) + digitVal;
        accBNext = (accB_q << 3) + (accB_q << 1) + digitVal;
        cntFull  = (cnt_q == CNT_WIDTH'(MAX_DIGITS));
    end

    // Next-state logic: frame parsing, command issue and the discard path
    always_comb begin
        state_t procState;
        logic   discard;

        state_d      = state_q;
        accA_d       = accA_q;
        accB_d       = accB_q;
        cnt_d        = cnt_q;
        opPending_d  = opPending_q;
        opcode_d     = opcode_q;
        operandA_d   = operandA_q;
        operandB_d   = operandB_q;
        cmdValid_d   = cmdValid_q;
        frameError_d = 1'b0;
        procState    = state_q;
        discard      = 1'b0;

        // a completing handshake lets a same-cycle byte start the next frame
        if (state_q == ISSUE && cmdValid_q && cmd_ready_i) begin
            cmdValid_d = 1'b0;
            state_d    = IDLE;
            procState  = IDLE;
        end

        if (byte_ready_i && !isSpace) begin
            case (procState)
                IDLE: begin
                    if (isDigit) begin
                        accA_d  = digitVal;
                        cnt_d   = CNT_WIDTH'(1);
                        state_d = OPA;
                    end else begin
                        discard = 1'b1;
                    end
                end
                OPA: begin
                    if (isDigit) begin
                        if (cntFull) begin
                            discard = 1'b1;
                        end else begin
                            accA_d = accANext;
                            cnt_d  = cnt_q + CNT_WIDTH'(1);
                        end
                    end else if (isOp) begin
                        opPending_d = opFromByte;
                        cnt_d       = '0;
                        accB_d      = '0;
                        state_d     = OPB;
                    end else begin
                        discard = 1'b1;
                    end
                end
                OPB: begin
                    if (isDigit) begin
                        if (cntFull) begin
                            discard = 1'b1;
                        end else begin
                            accB_d = accBNext;
                            cnt_d  = cnt_q + CNT_WIDTH'(1);
                        end
                    end else if (isTerm && cnt_q != '0) begin
                        operandA_d = accA_q;
                        operandB_d = accB_q;
                        opcode_d   = opPending_q;
                        cmdValid_d = 1'b1;
                        state_d    = ISSUE;
                    end else begin
                        discard = 1'b1;
                    end
                end
                ISSUE: begin
                    // pending command is kept; only the stray byte is reported
                    frameError_d = 1'b1;
                end
                default: begin
                    discard = 1'b1;
                end
            endcase
        end

`ifdef UART_CMD_TIMEOUT_EN
        // the gap timer only runs while a frame is partially received
        if (state_q == OPA || state_q == OPB) begin
            if (byte_ready_i) begin
                timer_d = '0;
            end else if (timer_q == TIMER_WIDTH'(TIMEOUT_LIMIT)) begin
                timer_d = '0;
                discard = 1'b1;
            end else begin
                timer_d = timer_q + TIMER_WIDTH'(1);
            end
        end else begin
            timer_d = '0;
        end
`endif

        if (discard) begin
            frameError_d = 1'b1;
            state_d      = IDLE;
            accA_d       = '0;
            accB_d       = '0;
            cnt_d        = '0;
`ifdef UART_CMD_TIMEOUT_EN
            timer_d      = '0;
`endif
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            accA_q       <= '0;
            accB_q       <= '0;
            cnt_q        <= '0;
            opPending_q  <= '0;
            opcode_q     <= '0;
            operandA_q   <= '0;
            operandB_q   <= '0;
            cmdValid_q   <= 1'b0;
            frameError_q <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
            timer_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            accA_q       <= accA_d;
            accB_q       <= accB_d;
            cnt_q        <= cnt_d;
            opPending_q  <= opPending_d;
            opcode_q     <= opcode_d;
            operandA_q   <= operandA_d;
            operandB_q   <= operandB_d;
            cmdValid_q   <= cmdValid_d;
            frameError_q <= frameError_d;
`ifdef UART_CMD_TIMEOUT_EN
            timer_q      <= timer_d;
`endif
        end
    end

    assign cmd_valid_o   = cmdValid_q;
    assign operand_a_o   = operandA_q;
    assign operand_b_o   = operandB_q;
    assign opcode_o      = opcode_q;
    assign frame_error_o = frameError_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb_uart_cmd_sequencer
// Scoreboard bench: stimulus pushes expected commands, a monitor pops and
// compares on every handshake and tallies frame_error pulses.
module tb_uart_cmd_sequencer;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TB_TIMEOUT_MS = 1;
`else
    localparam int TB_TIMEOUT_MS = 100;
`endif

    logic        clock;
    logic        reset_n;
    logic [7:0]  byteData;
    logic        byteReady;
    logic        cmdValid;
    logic        cmdReady;
    logic [15:0] operandA;
    logic [15:0] operandB;
    logic [1:0]  opcode;
    logic        frameError;
    logic        busy;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
    } cmd_t;

    cmd_t expQ[$];
    int   checks      = 0;
    int   failures    = 0;
    int   errSeen     = 0;
    int   errExpected = 0;

    uart_cmd_sequencer #(
        .OPERAND_WIDTH  (16),
        .MAX_DIGITS     (4),
        .CLOCK_FREQUENCY(50000000),
        .TIMEOUT_MS     (TB_TIMEOUT_MS)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .byte_data_i  (byteData),
        .byte_ready_i (byteReady),
        .cmd_valid_o  (cmdValid),
        .cmd_ready_i  (cmdReady),
        .operand_a_o  (operandA),
        .operand_b_o  (operandB),
        .opcode_o     (opcode),
        .frame_error_o(frameError),
        .busy_o       (busy)
    );

    // Free-running 100 MHz clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Compare one observed value with its expected value
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Present one byte strobe for a single clock edge
    task automatic sendByte(input logic [7:0] b);
        byteData  = b;
        byteReady = 1'b1;
        @(posedge clock);
        #1;
        byteReady = 1'b0;
    endtask

    // Send a string of bytes back to back
    task automatic applyStimulus(input string s);
        for (int i = 0; i < s.len(); i++) begin
            sendByte(s[i]);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pushExp(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        cmd_t c;
        c.a  = a;
        c.b  = b;
        c.op = op;
        expQ.push_back(c);
    endtask

    // Monitor: pop and compare on every handshake, count error pulses
    always @(negedge clock) begin
        if (reset_n) begin
            if (frameError) errSeen++;
            if (cmdValid && cmdReady) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpectedCmd actual a=%0d b=%0d op=%0d required none",
                             operandA, operandB, opcode);
                end else begin
                    cmd_t e;
                    e = expQ.pop_front();
                    checkOutput("cmdA", {16'd0, operandA}, {16'd0, e.a});
                    checkOutput("cmdB", {16'd0, operandB}, {16'd0, e.b});
                    checkOutput("cmdOp", {30'd0, opcode}, {30'd0, e.op});
                end
            end
        end
    end

    // Directed stimulus sequence
    initial begin
        int waited;
        reset_n   = 1'b0;
        byteData  = 8'h00;
        byteReady = 1'b0;
        cmdReady  = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rstValid", {31'd0, cmdValid}, 0);
        checkOutput("rstBusy", {31'd0, busy}, 0);
        checkOutput("rstErr", {31'd0, frameError}, 0);
        checkOutput("rstA", {16'd0, operandA}, 0);
        reset_n = 1'b1;
        idleCycles(2);

        $display("[TB] test 1: 12+34 CR with ready high");
        pushExp(16'd12, 16'd34, 2'd0);
        applyStimulus("12+34\015");
        checkOutput("t1Latency", {31'd0, cmdValid}, 1);
        idleCycles(1);
        checkOutput("t1ValidDrop", {31'd0, cmdValid}, 0);
        checkOutput("t1BusyDrop", {31'd0, busy}, 0);

        $display("[TB] test 2: 7 * 9= held for 20 cycles");
        cmdReady = 1'b0;
        pushExp(16'd7, 16'd9, 2'd2);
        applyStimulus("7 * 9=");
        checkOutput("t2Latency", {31'd0, cmdValid}, 1);
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                errExpected++;
                sendByte("5");
            end else if (i == 5) begin
                sendByte(" ");
            end else begin
                idleCycles(1);
            end
            checkOutput("t2HoldValid", {31'd0, cmdValid}, 1);
            checkOutput("t2HoldA", {16'd0, operandA}, 7);
            checkOutput("t2HoldB", {16'd0, operandB}, 9);
            checkOutput("t2HoldOp", {30'd0, opcode}, 2);
        end
        cmdReady = 1'b1;
        idleCycles(1);
        checkOutput("t2ValidDrop", {31'd0, cmdValid}, 0);
        checkOutput("t2Err", errSeen, errExpected);

        $display("[TB] test 3: too many digits");
        applyStimulus("12345+1\015");
        errExpected += 3;
        idleCycles(2);
        checkOutput("t3Busy", {31'd0, busy}, 0);
        checkOutput("t3Err", errSeen, errExpected);

        $display("[TB] test 4: missing operands");
        applyStimulus("+3\015");
        errExpected += 2;
        applyStimulus("8/\015");
        errExpected += 1;
        idleCycles(2);
        checkOutput("t4Busy", {31'd0, busy}, 0);
        checkOutput("t4Err", errSeen, errExpected);

        $display("[TB] test 4b: four-digit operands accepted");
        pushExp(16'd1234, 16'd5678, 2'd3);
        applyStimulus("1234/5678\015");
        idleCycles(2);

        $display("[TB] test 4c: byte on the same cycle as the handshake");
        cmdReady = 1'b0;
        pushExp(16'd5, 16'd2, 2'd1);
        applyStimulus("5-2=");
        idleCycles(3);
        byteData  = "6";
        byteReady = 1'b1;
        cmdReady  = 1'b1;
        @(posedge clock);
        #1;
        byteReady = 1'b0;
        checkOutput("t4cValidDrop", {31'd0, cmdValid}, 0);
        checkOutput("t4cBusy", {31'd0, busy}, 1);
        pushExp(16'd6, 16'd1, 2'd0);
        applyStimulus("+1=");
        idleCycles(2);
        checkOutput("t4cErr", errSeen, errExpected);

`ifdef UART_CMD_TIMEOUT_EN
        $display("[TB] test 5: inter-byte timeout");
        applyStimulus("12");
        waited = 0;
        while (!frameError && waited < 50100) begin
            idleCycles(1);
            waited++;
        end
        errExpected++;
        checkOutput("t5Fired", {31'd0, frameError}, 1);
        checkOutput("t5Window", {31'd0, (waited >= 49990 && waited <= 50010)}, 1);
        idleCycles(1);
        checkOutput("t5Busy", {31'd0, busy}, 0);
`else
        $display("[TB] test 5: partial frame waits");
        waited = 0;
        applyStimulus("12");
        idleCycles(200);
        checkOutput("t5Busy", {31'd0, busy}, 1);
        checkOutput("t5NoErr", {31'd0, frameError}, waited);
        pushExp(16'd12, 16'd3, 2'd1);
        applyStimulus("-3\015");
        idleCycles(2);
`endif
        checkOutput("t5Err", errSeen, errExpected);

        $display("[TB] test 6: reset mid-frame");
        applyStimulus("99*");
        reset_n = 1'b0;
        idleCycles(1);
        checkOutput("t6Valid", {31'd0, cmdValid}, 0);
        checkOutput("t6Busy", {31'd0, busy}, 0);
        checkOutput("t6Err", {31'd0, frameError}, 0);
        checkOutput("t6A", {16'd0, operandA}, 0);
        checkOutput("t6B", {16'd0, operandB}, 0);
        checkOutput("t6Op", {30'd0, opcode}, 0);
        reset_n = 1'b1;
        pushExp(16'd4, 16'd4, 2'd0);
        applyStimulus("4+4\015");
        idleCycles(3);

        checkOutput("queueEmpty", expQ.size(), 0);
        checkOutput("finalErr", errSeen, errExpected);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
